// File: rtl/data_memory_pipe.sv
// ---------------------------------------------------------------------------
// data_memory_pipe
//
// Byte-addressable data memory for the load/store stage. Requests arrive on a
// valid/ready handshake. Each request produces exactly one response, and
// responses leave in acceptance order after a configurable read latency.
// Sub-word loads are sign- or zero-extended here. A request is flagged as an
// error, with no memory side effect, when it has an illegal length, is
// misaligned, or is out of range.
//
// Parameters
//   ADDR_WIDTH     byte-address bits decoded; memory is 2^ADDR_WIDTH bytes
//   READ_LATENCY   response pipeline depth, legal 1..4
//   MEM_INIT_FILE  optional initial image name
//
// Ports
//   SYS_clk     clock, rising edge
//   SYS_reset   asynchronous active-low reset (clears the pipeline only)
//   req_valid   request present
//   req_ready   request accepted this cycle (combinational)
//   req_write   1 = store, 0 = load
//   req_length  01 byte, 10 half, 11 word, 00 illegal
//   req_signed  load extension: 1 = sign, 0 = zero
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   resp_valid  response present
//   resp_ready  consumer takes the response
//   resp_write  store/load flag of the responding request
//   resp_rdata  load result (0 for stores and errors)
//   resp_error  the request was rejected
// ---------------------------------------------------------------------------
module data_memory_pipe #(
    parameter int    ADDR_WIDTH    = 12,
    parameter int    READ_LATENCY  = 1,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_length,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_write,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int MEM_BYTES = 1 << ADDR_WIDTH;
    localparam int LAST      = READ_LATENCY - 1;

    // Extend the right-aligned raw load data according to access size.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  len,
                                                input logic        sgn);
        logic [31:0] res;
        case (len)
            2'b01:   res = {{24{sgn & raw[7]}},  raw[7:0]};
            2'b10:   res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] lane_enables(input logic [1:0] len,
                                                input logic [1:0] ofs);
        logic [3:0] base;
        case (len)
            2'b01:   base = 4'b0001;
            2'b10:   base = 4'b0011;
            2'b11:   base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << ofs;
    endfunction

    // Storage: no reset, contents survive SYS_reset.
    logic [7:0] mem [MEM_BYTES];

    // Response pipeline, index 0 is the stage filled on the accept edge.
    logic        vld_p   [READ_LATENCY];
    logic        write_p [READ_LATENCY];
    logic [31:0] rdata_p [READ_LATENCY];
    logic        error_p [READ_LATENCY];

    logic                  advance;
    logic                  accept;
    logic                  addr_hi_nz;
    logic                  req_err;
    logic [ADDR_WIDTH-3:0] widx;
    logic [4:0]            shamt;
    logic [31:0]           rd_word;
    logic [31:0]           rd_aligned;
    logic [31:0]           ld_data;
    logic [3:0]            wr_be;
    logic [31:0]           wr_bytes;
    logic                  mem_we;

    assign advance   = !resp_valid || resp_ready;
    assign req_ready = advance;
    assign accept    = req_valid && advance;

    // Any set bit above the decoded range is out of range; no wrap-around.
    assign addr_hi_nz = |(req_addr >> ADDR_WIDTH);

    assign req_err = (req_length == 2'b00)
                  || addr_hi_nz
                  || (req_length == 2'b10 && req_addr[0])
                  || (req_length == 2'b11 && req_addr[1:0] != 2'b00);

    // Accesses are naturally aligned once error-free, so every byte of an
    // access lives in the single word at widx; the byte offset selects lanes.
    assign widx  = req_addr[ADDR_WIDTH-1:2];
    assign shamt = {req_addr[1:0], 3'b000};

    assign rd_word = {mem[{widx, 2'd3}], mem[{widx, 2'd2}],
                      mem[{widx, 2'd1}], mem[{widx, 2'd0}]};
    assign rd_aligned = rd_word >> shamt;

    assign ld_data = (req_write || req_err) ? 32'd0
                   : extend_load(rd_aligned, req_length, req_signed);

    assign wr_be    = lane_enables(req_length, req_addr[1:0]);
    assign wr_bytes = req_wdata << shamt;

    // Reset gates the write so nothing lands in memory while it is held.
    assign mem_we = SYS_reset && accept && req_write && !req_err;

    always @(posedge SYS_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[{widx, 2'(i)}] <= wr_bytes[8*i +: 8];
            end
        end
    end

    // Stage 1 captures the request result; later stages shift in lockstep.
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else if (advance) begin
            vld_p[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (advance) begin
            write_p[0] <= req_write;
            rdata_p[0] <= ld_data;
            error_p[0] <= req_err;
            for (int i = 1; i < READ_LATENCY; i++) begin
                write_p[i] <= write_p[i-1];
                rdata_p[i] <= rdata_p[i-1];
                error_p[i] <= error_p[i-1];
            end
        end
    end

    // Output stage: payload is masked by valid, so it reads as zero during
    // reset and while idle even though the data registers are not reset.
    assign resp_valid = vld_p[LAST];
    assign resp_write = resp_valid & write_p[LAST];
    assign resp_rdata = resp_valid ? rdata_p[LAST] : 32'd0;
    assign resp_error = resp_valid & error_p[LAST];

endmodule

// File: tb/tb_data_memory_pipe.sv
module tb_data_memory_pipe;

    localparam int AW = 12;
    localparam int RL = 3;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_length;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_write;
    logic [31:0] resp_rdata;
    logic        resp_error;

    always #5 SYS_clk = ~SYS_clk;

    data_memory_pipe #(
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL),
        .MEM_INIT_FILE("")
    ) dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_length(req_length),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_write(resp_write),
        .resp_rdata(resp_rdata),
        .resp_error(resp_error)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        bit          chk_lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   stall_drops;

    always @(posedge SYS_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: a response is taken on the edge after this sample.
    always @(negedge SYS_clk) begin
        if (SYS_reset && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, expected no response",
                         resp_rdata, resp_error);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_resp{wr,err,rdata}"},
                      64'({resp_write, resp_error, resp_rdata}),
                      64'({mon_e.wr, mon_e.err, mon_e.rdata}));
                if (mon_e.chk_lat)
                    check({mon_e.name, "_latency_edges"}, 64'(cyc - mon_e.acc), 64'(RL - 1));
            end
        end
    end

    task automatic add_vec(input string name, input logic wr, input logic [1:0] len,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.wr = wr; v.len = len; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input string name, input logic wr, input logic [1:0] len,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit chk_lat);
        exp_t e;
        int   waited;
        req_valid  = 1'b1;
        req_write  = wr;
        req_length = len;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        waited     = 0;
        @(negedge SYS_clk);
        while (!req_ready && waited < 50) begin
            @(posedge SYS_clk);
            @(negedge SYS_clk);
            waited++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: req_ready 0 after 50 cycles, expected 1", name);
        end else begin
            e.name = name; e.wr = wr; e.rdata = exp_rdata; e.err = exp_err;
            e.acc = cyc + 1; e.chk_lat = chk_lat;
            sb_q.push_back(e);
        end
        @(posedge SYS_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(negedge SYS_clk);
            w++;
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
        @(posedge SYS_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        SYS_reset  = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_length = 2'b11;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge SYS_clk);
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_write", 64'(resp_write), 64'(0));
        check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        check("rst_resp_error", 64'(resp_error), 64'(0));
        check("rst_req_ready",  64'(req_ready),  64'(1));
        @(posedge SYS_clk); #1;
        SYS_reset = 1'b1;

        // Store blocked by reset leaves memory untouched
        issue("st_a5_30", 1'b1, 2'b11, 1'b0, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        drain("st_a5_30");
        SYS_reset  = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_length = 2'b11;
        req_addr   = 32'h30;
        req_wdata  = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge SYS_clk);
            check("rst_hold_resp_valid", 64'(resp_valid), 64'(0));
            check("rst_hold_req_ready",  64'(req_ready),  64'(1));
            @(posedge SYS_clk); #1;
        end
        req_valid = 1'b0;
        SYS_reset = 1'b1;
        @(negedge SYS_clk);
        check("post_rst_req_ready", 64'(req_ready), 64'(1));
        @(posedge SYS_clk); #1;
        issue("ld_30_after_rst", 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        drain("ld_30_after_rst");

        // Table of sizes, extension and error cases, issued back-to-back
        add_vec("st_w10",     1'b1, 2'b11, 1'b0, 32'h10,       32'h80FF7F01, 32'h0,        1'b0);
        add_vec("lb_s10",     1'b0, 2'b01, 1'b1, 32'h10,       32'h0,        32'h00000001, 1'b0);
        add_vec("lb_s12",     1'b0, 2'b01, 1'b1, 32'h12,       32'h0,        32'hFFFFFFFF, 1'b0);
        add_vec("lh_u12",     1'b0, 2'b10, 1'b0, 32'h12,       32'h0,        32'h000080FF, 1'b0);
        add_vec("lh_s12",     1'b0, 2'b10, 1'b1, 32'h12,       32'h0,        32'hFFFF80FF, 1'b0);
        add_vec("lb_u12",     1'b0, 2'b01, 1'b0, 32'h12,       32'h0,        32'h000000FF, 1'b0);
        add_vec("lw_10",      1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'h80FF7F01, 1'b0);
        add_vec("lw_mis11",   1'b0, 2'b11, 1'b0, 32'h11,       32'h0,        32'h0,        1'b1);
        add_vec("sh_mis13",   1'b1, 2'b10, 1'b0, 32'h13,       32'h00001234, 32'h0,        1'b1);
        add_vec("lw_10_keep", 1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'h80FF7F01, 1'b0);
        add_vec("ld_len00",   1'b0, 2'b00, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1);
        add_vec("lw_1000",    1'b0, 2'b11, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1);
        add_vec("lw_hi_bit",  1'b0, 2'b11, 1'b0, 32'h80000010, 32'h0,        32'h0,        1'b1);
        add_vec("st_len00",   1'b1, 2'b00, 1'b0, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b1);
        add_vec("sb_13",      1'b1, 2'b01, 1'b0, 32'h13,       32'h000000AB, 32'h0,        1'b0);
        add_vec("lw_10_sb",   1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'hABFF7F01, 1'b0);
        add_vec("lh_s10",     1'b0, 2'b10, 1'b1, 32'h10,       32'h0,        32'h00007F01, 1'b0);
        add_vec("st_wffc",    1'b1, 2'b11, 1'b0, 32'hFFC,      32'h11223344, 32'h0,        1'b0);
        add_vec("lw_ffc",     1'b0, 2'b11, 1'b0, 32'hFFC,      32'h0,        32'h11223344, 1'b0);
        add_vec("lb_s_fff",   1'b0, 2'b01, 1'b1, 32'hFFF,      32'h0,        32'h00000011, 1'b0);
        add_vec("lh_s_ffe",   1'b0, 2'b10, 1'b1, 32'hFFE,      32'h0,        32'h00001122, 1'b0);
        for (int i = 0; i < vecs.size(); i++)
            issue(vecs[i].name, vecs[i].wr, vecs[i].len, vecs[i].sgn, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
        drain("table");

        // Store then load to the same word on consecutive edges
        issue("st_w20", 1'b1, 2'b11, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
        issue("lw_20",  1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        drain("raw_20");

        // Backpressure mid-stream
        stall_drops = 0;
        fork
            begin
                issue("bp_lb10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00000001, 1'b0, 1'b0);
                issue("bp_lb11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0, 1'b0);
                issue("bp_lb12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h000000FF, 1'b0, 1'b0);
                issue("bp_lb13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h000000AB, 1'b0, 1'b0);
                issue("bp_lw10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hABFF7F01, 1'b0, 1'b0);
            end
            begin
                @(posedge SYS_clk); #1;
                resp_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge SYS_clk);
                    if (!req_ready) stall_drops++;
                    @(posedge SYS_clk); #1;
                end
                resp_ready = 1'b1;
            end
        join
        drain("backpressure");
        check("bp_req_ready_low_cycles", 64'(stall_drops), 64'(2));

        // Reset with two responses in flight
        resp_ready = 1'b0;
        issue("fl_lw20", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        issue("fl_lw10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hABFF7F01, 1'b0, 1'b0);
        repeat (2) @(negedge SYS_clk);
        check("inflight_resp_valid", 64'(resp_valid), 64'(1));
        #2;
        SYS_reset = 1'b0;
        #1;
        check("inflight_rst_resp_valid", 64'(resp_valid), 64'(0));
        check("inflight_rst_resp_rdata", 64'(resp_rdata), 64'(0));
        sb_q.delete();
        @(posedge SYS_clk); #1;
        resp_ready = 1'b1;
        SYS_reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge SYS_clk);
            check("after_rst_no_resp", 64'(resp_valid), 64'(0));
        end
        @(posedge SYS_clk); #1;
        issue("post_rst_lw20", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        issue("post_rst_lw10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hABFF7F01, 1'b0, 1'b0);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
